shift4_sched: RTL

SHIFT4_SCHED -- requirements
Module: shift4_sched

---
 rtl/shift4_pkg.sv | 22 ++
 rtl/shift4_core.sv | 24 ++
 rtl/shift4_sched.sv | 98 +++++++++
 3 files changed

// File: rtl/shift4_pkg.sv
// shift4_pkg: shared state encoding, frame geometry and round-robin pick for shift4_sched.
// Frame length grows to 5 when SHIFT4_SCHED_PARITY_EN is defined.
package shift4_pkg;

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int FRAME_LEN_BASE = 4;
    localparam int NREQ           = 2;
`ifdef SHIFT4_SCHED_PARITY_EN
    localparam int FRAME_LEN      = FRAME_LEN_BASE + 1;
`else
    localparam int FRAME_LEN      = FRAME_LEN_BASE;
`endif
    localparam logic [2:0] LAST_CNT = 3'(FRAME_LEN - 1);

    // Preferred requester wins if asking, otherwise the other one.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] req, input logic ptr);
        return ptr ? (req[1] ? 2'b10 : req[0] ? 2'b01 : 2'b00)
                   : (req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00);
    endfunction

endpackage

// File: rtl/shift4_core.sv
// shift4_core: 4-bit right shift register, zero fill; load takes priority over ena.
module shift4_core (
    input  logic       clk,
    input  logic       areset,
    input  logic       i_load,
    input  logic       i_ena,
    input  logic [3:0] i_data,
    output logic [3:0] o_q
);

    logic [3:0] r_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            r_q <= '0;
        else if (i_load)
            r_q <= i_data;
        else if (i_ena)
            r_q <= {1'b0, r_q[3:1]};
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift4_sched.sv
// shift4_sched: two-requester round-robin scheduler serialising 4-bit payloads LSB first.
// Define SHIFT4_SCHED_PARITY_EN to append an even-parity bit as a 5th frame bit.
module shift4_sched
    import shift4_pkg::*;
(
    input  logic            clk,
    input  logic            areset,
    input  logic [NREQ-1:0] req,
    input  logic [3:0]      data0,
    input  logic [3:0]      data1,
    output logic [NREQ-1:0] gnt,
    output logic            sout,
    output logic            sout_valid,
    output logic            sof,
    output logic            eof,
    output logic            owner
);

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic            r_ptr, w_ptr_nxt;
    logic            r_owner, w_owner_nxt;
    logic [3:0]      w_q, w_data;
    logic [NREQ-1:0] w_gnt;
    logic            w_shift, w_eof, w_load, w_ena, w_sel;

    assign w_shift = (r_state == SHIFT);
    assign w_eof   = w_shift && (r_cnt == LAST_CNT);
    // Grant is masked during reset so nothing is offered while the block is held.
    assign w_gnt   = (areset || (w_shift && !w_eof)) ? '0 : rr_pick(req, r_ptr);
    assign w_load  = |w_gnt;
    assign w_sel   = w_gnt[1];
    assign w_data  = w_sel ? data1 : data0;
    assign w_ena   = w_shift && !w_load;

    shift4_core u_core (
        .clk    (clk),
        .areset (areset),
        .i_load (w_load),
        .i_ena  (w_ena),
        .i_data (w_data),
        .o_q    (w_q)
    );

`ifdef SHIFT4_SCHED_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            r_par <= 1'b0;
        else if (w_load)
            r_par <= ^w_data;
    end

    assign sout = w_shift && ((r_cnt == 3'(FRAME_LEN_BASE)) ? r_par : w_q[0]);
`else
    assign sout = w_shift && w_q[0];
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
            w_owner_nxt = w_sel;
            w_ptr_nxt   = ~w_sel;
        end else if (w_eof) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (w_shift) begin
            w_cnt_nxt   = r_cnt + 3'd1;
        end
    end

    assign gnt        = w_gnt;
    assign sout_valid = w_shift;
    assign sof        = w_shift && (r_cnt == 3'd0);
    assign eof        = w_eof;
    assign owner      = r_owner;

endmodule
